// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 constants and FSM state type for the multiplier core
package fp_pkg;

  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MAX  = 10'sd255;
  localparam logic [30:0]       INF_MAG  = 31'h7F800000;
  localparam logic [31:0]       QNAN     = 32'h7FFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_mult_core_if.sv
// rtl/fp_mult_core_if.sv - request/result bundle between the multiplier core and its requester
interface fp_mult_core_if;

  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] temp_result;
  logic [31:0] op1_out;
  logic [31:0] op2_out;

  modport master (
    output start, in1, in2,
    input  busy, done, temp_result, op1_out, op2_out
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, temp_result, op1_out, op2_out
  );

endinterface

// File: rtl/fp_round.sv
// rtl/fp_round.sv - rounding, renormalization and overflow/underflow packing (RNE when FP_MULT_RNE_EN is defined)
module fp_round
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic              zero_i,
  input  logic signed [9:0] exp_i,
  input  logic [23:0]       mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [31:0]       result_o
);

  logic              round_up;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic signed [9:0] exp_r;

`ifndef FP_MULT_RNE_EN
  // Truncation ignores the bits below the fraction.
  logic unused_round_bits;
  assign unused_round_bits = guard_i ^ sticky_i;
`endif

  // Round the 24-bit significand, renormalize on carry-out, then pack with range checks.
  always_comb begin
    round_up = 1'b0;
`ifdef FP_MULT_RNE_EN
    round_up = guard_i & (sticky_i | mant_i[0]);
`endif
    sum = {1'b0, mant_i} + {24'd0, round_up};
    if (sum[24]) begin
      frac  = sum[23:1];
      exp_r = exp_i + 10'sd1;
    end else begin
      frac  = sum[22:0];
      exp_r = exp_i;
    end

    if (zero_i) begin
      result_o = {sign_i, 31'b0};
    end else if (exp_r >= EXP_MAX) begin
      result_o = {sign_i, INF_MAG};
    end else if (exp_r <= 10'sd0) begin
      result_o = {sign_i, 31'b0};
    end else begin
      result_o = {sign_i, exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_mult_core.sv
// rtl/fp_mult_core.sv - multi-cycle binary32 multiplier, normal path only (FP_MULT_RNE_EN selects round-to-nearest-even)
module fp_mult_core
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp_mult_core_if.slave bus
);

  state_t            state_q,  state_d;
  logic [4:0]        cnt_q,    cnt_d;
  logic [31:0]       a_q,      a_d;
  logic [31:0]       b_q,      b_d;
  logic [23:0]       mplier_q, mplier_d;
  logic [47:0]       prod_q,   prod_d;
  logic [23:0]       mant_q,   mant_d;
  logic              guard_q,  guard_d;
  logic              sticky_q, sticky_d;
  logic signed [9:0] exp_q,    exp_d;
  logic [31:0]       res_q,    res_d;
  logic [31:0]       op1_q,    op1_d;
  logic [31:0]       op2_q,    op2_d;

  logic [24:0]       add_sum;
  logic signed [9:0] exp_sum;
  logic [31:0]       round_res;
  logic              zero_op;

  assign zero_op = (a_q[30:23] == 8'd0) || (b_q[30:23] == 8'd0);

  fp_round u_round (
    .sign_i   (a_q[31] ^ b_q[31]),
    .zero_i   (zero_op),
    .exp_i    (exp_q),
    .mant_i   (mant_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .result_o (round_res)
  );

  // Next-state and datapath: right-shifting shift-add multiply, then normalize and round.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    exp_d    = exp_q;
    res_d    = res_q;
    op1_d    = op1_q;
    op2_d    = op2_q;

    // Upper half of the partial product plus the multiplicand when the current multiplier bit is set.
    add_sum = {1'b0, prod_q[47:24]} + (mplier_q[0] ? {2'b01, a_q[22:0]} : 25'd0);
    exp_sum = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - EXP_BIAS;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.in1;
          b_d      = bus.in2;
          mplier_d = {1'b1, bus.in2[22:0]};
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        prod_d   = {add_sum, prod_q[23:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = NORM;
        end
      end
      NORM: begin
        // Product lies in [2^46, 2^48); pick the window that puts the leading one at mant[23].
        if (prod_q[47]) begin
          mant_d   = prod_q[47:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_sum + 10'sd1;
        end else begin
          mant_d   = prod_q[46:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
          exp_d    = exp_sum;
        end
        state_d = ROUND;
      end
      ROUND: begin
        res_d   = round_res;
        op1_d   = a_q;
        op2_d   = b_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      res_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      res_q    <= res_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.temp_result = res_q;
  assign bus.op1_out     = op1_q;
  assign bus.op2_out     = op2_q;

endmodule

// File: doc/fp_mult_core.md
FP_MULT_CORE -- requirements
Module: fp_mult_core

Interface
REQ-001 SHALL have parameter: none; all widths fixed to IEEE754 binary32.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin one multiply; sampled only in IDLE.
REQ-005 SHALL have port: in1  input  32  operand A, binary32; sampled with start.
REQ-006 SHALL have port: in2  input  32  operand B, binary32; sampled with start.
REQ-007 SHALL have port: busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-008 SHALL have port: done  output  1  single-cycle pulse; temp_result valid.
REQ-009 SHALL have port: temp_result  output  32  normal-path product for the downstream special-case stage.
REQ-010 SHALL have ports: op1_out, op2_out  output  32  captured in1/in2, aligned with temp_result for the special-case stage.

Function
REQ-011 SHALL use states IDLE -> MULT -> NORM -> ROUND -> DONE -> IDLE.
REQ-012 IDLE: start=1 at cycle T SHALL capture operands, clear accumulator and counter, and enter MULT at T+1.
REQ-013 MULT: 24-bit x 24-bit shift-add, one multiplier bit per cycle, SHALL take 24 cycles (T+1..T+24), then NORM.
REQ-014 Significands SHALL be {1,frac}; an operand with exponent field 0 SHALL force temp_result = {sign,31'b0}.
REQ-015 Sign SHALL equal in1[31]^in2[31] in every case, including overflow, underflow and zero.
REQ-016 NORM (T+25): unbiased exponent e = e1+e2-127 in 10-bit signed; if product bit 47 is set, shift right by 1 and e=e+1.
REQ-017 ROUND (T+26): 23-bit fraction from the normalized product; rounding per REQ-024/025; a rounding carry out of the fraction SHALL renormalize, with e=e+1.
REQ-018 After rounding: e>=255 -> temp_result={sign,31'h7F800000}; e<=0 -> {sign,31'b0} (flush, no subnormals); else {sign,e[7:0],frac}.
REQ-019 DONE (T+27): done=1 for exactly one cycle; return to IDLE at T+28. Latency from start to done SHALL be 27 cycles.
REQ-020 temp_result, op1_out and op2_out SHALL hold their values until the next DONE.
REQ-021 start SHALL be ignored in MULT, NORM, ROUND and DONE; there is no queueing.

Reset
REQ-022 rst=1 at any clock edge, including mid-MULT, SHALL force IDLE, busy=0, done=0, temp_result=0, op1_out=0, op2_out=0, and clear the accumulator and counter.
REQ-023 When rst and start are both 1, rst SHALL win and no operation SHALL start.

Configuration
REQ-024 With FP_MULT_RNE_EN defined, ROUND SHALL apply round-to-nearest-even using guard and sticky bits from the 48-bit product.
REQ-025 Without FP_MULT_RNE_EN, ROUND SHALL truncate; the cycle count stays unchanged in both builds.

Structure
REQ-026 Shared package fp_pkg SHALL hold: EXP_BIAS=127, EXP_MAX=255, INF_MAG=31'h7F800000, QNAN=32'h7FFFFFFF, state enum typedef.
REQ-027 Sub-module fp_round SHALL be the one natural sub-module: combinational rounding, renormalization and overflow/underflow packing.

Verification
REQ-028 start, in1=0x3FC00000, in2=0x40000000 -> done at T+27, temp_result=0x40400000; op1_out/op2_out echo the inputs.
REQ-029 in1=0x3FC00000, in2=0x3FC00000 -> 0x40100000 (NORM shift path).
REQ-030 in1=0x3FC00001, in2=0x3FC00001 -> 0x40100002 with FP_MULT_RNE_EN; 0x40100001 without.
REQ-031 in1=0xFF000000, in2=0x7F000000 -> 0xFF800000; in1=in2=0x00800000 -> 0x00000000.
REQ-032 Assert rst at T+10 of an operation -> next cycle busy=0, done=0, temp_result=0; a fresh start then completes normally.
REQ-033 Pulse start again at T+5 with different operands -> ignored; result matches the first operands only.
